button_debouncer: RTL and testbench
===================================

# button_debouncer

Debounces and synchronises a raw mechanical push-button input on the 12 MHz Alhambra II clock. It produces a clean level and single-cycle press, release and long-press event pulses. It sits directly upstream of the LED toggle stage, whose button input is driven from `PRESS`. Bounce, glitches and metastability never reach downstream logic.

## Interface

Parameters:

- `DEBOUNCE_CYCLES`, default 240000: consecutive stable samples required to accept a new level (20 ms at 12 MHz). Legal range is 2 or more.
- `LONG_PRESS_CYCLES`, default 12000000: cycles the press must be held after it is accepted before `LONG_PRESS` fires (1 s). A value of 0 disables long-press.
- `ACTIVE_LOW`, default 0: when 1, `BTN` is inverted at the input, so a pressed button reads low.

Ports:

- `CLK`, input, 1 bit: system clock, 12 MHz, rising-edge.
- `RST`, input, 1 bit: reset, synchronous, active-high.
- `BTN`, input, 1 bit: raw asynchronous button pin.
- `BTN_STABLE`, output, 1 bit: debounced level, 1 = pressed.
- `PRESS`, output, 1 bit: one-cycle pulse when a press is accepted.
- `RELEASE`, output, 1 bit: one-cycle pulse when a release is accepted.
- `LONG_PRESS`, output, 1 bit: one-cycle pulse, at most once per press.

## Operation

**Input path**
- `BTN` is XORed with `ACTIVE_LOW`, then passed through a 2-flop synchroniser (`s1`, `s2`).
- All decisions use `s2` only.

**Counters**
- Debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- Hold counter width is `$clog2(LONG_PRESS_CYCLES+1)`.
- Both counters are unsigned and saturate; they never wrap.

**State machine** (4 states):
- IDLE (stable released):
  - if `s2`=1, go to PRESS_WAIT with the debounce count set to 1.
- PRESS_WAIT:
  - if `s2`=0, go back to IDLE and clear the count. No output change.
  - if `s2`=1, increment the count.
  - when the count reaches `DEBOUNCE_CYCLES`, go to PRESSED. On that edge set `BTN_STABLE`=1, pulse `PRESS`, and clear the hold counter.
- PRESSED:
  - the hold counter increments every cycle.
  - when it reaches `LONG_PRESS_CYCLES` (and the parameter is not 0), pulse `LONG_PRESS` once. The counter then saturates, so there is no repeat.
  - if `s2`=0, go to RELEASE_WAIT with the debounce count set to 1. The hold counter freezes.
- RELEASE_WAIT:
  - if `s2`=1, go back to PRESSED. The hold counter resumes without being cleared, so a bounce during release does not restart long-press timing.
  - when the count reaches `DEBOUNCE_CYCLES`, go to IDLE. On that edge set `BTN_STABLE`=0 and pulse `RELEASE`.

**Output rules**
- A partial debounce interrupted by the opposite level discards all progress. There is no hysteresis accumulation.
- `PRESS` and `RELEASE` strictly alternate. The first event after reset is always `PRESS`.
- `LONG_PRESS` only ever occurs between a `PRESS` and the following `RELEASE`.
- `PRESS`, `RELEASE` and `LONG_PRESS` never assert in the same cycle.
  - `LONG_PRESS` cannot coincide with `PRESS`: the hold count starts at 0 on the `PRESS` edge.
  - If the long-press threshold is reached in the same cycle release debouncing completes, `LONG_PRESS` is not emitted, because the hold counter is frozen in RELEASE_WAIT.

**Reset**
- `RST`=1 on a rising edge clears `s1` and `s2`, the state (to IDLE), both counters and all outputs.
- Reset mid-debounce or mid-hold aborts silently. No pulse is emitted for the aborted activity.
- If the button is still held when reset is released, it is debounced afresh and produces a `PRESS`.

## Timing

- Reset values: `BTN_STABLE`=0, `PRESS`=0, `RELEASE`=0, `LONG_PRESS`=0.
- All outputs are registered; there is no combinational path from `BTN`.
- Press latency: `BTN` is held at 1 starting at the edge that first samples it. `PRESS` is high after edge number `DEBOUNCE_CYCLES`+2, counting that first edge as edge 1:
  - 2 edges for the synchroniser;
  - `DEBOUNCE_CYCLES` edges for the debounce count.
- Release latency is identical, measured to `RELEASE`.
- `LONG_PRESS` rises `LONG_PRESS_CYCLES` edges after `PRESS` rises, provided there was no release bounce.
- A pulse shorter than `DEBOUNCE_CYCLES` cycles (after synchronisation) produces no output activity at all.
- Every pulse output is exactly 1 cycle wide.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=8, `LONG_PRESS_CYCLES`=32 and `ACTIVE_LOW`=0.

1. **Reset values.** Hold `RST` for 3 cycles with `BTN`=1. → All outputs stay 0 throughout reset. `PRESS` fires exactly 10 cycles after `RST` is released.
2. **Clean press and release.** `BTN` 0→1 held for 20 cycles, then 1→0. → `PRESS` is high for 1 cycle at edge 10. `BTN_STABLE` is 1 from that edge on. `RELEASE` fires 10 edges after the falling input. No `LONG_PRESS`.
3. **Glitch rejection.** `BTN`=1 for 7 cycles, then 0. → No pulses, `BTN_STABLE` stays 0. Repeat with a bouncing pattern of 1,0,1,1,0, then 1 held. → Exactly one `PRESS`, 10 edges after the final rising input.
4. **Long press.** Hold `BTN`=1 for 60 cycles. → `PRESS` at edge 10. `LONG_PRESS` at edge 42, once only. After release, `RELEASE` fires and there is no second `LONG_PRESS`.
5. **Release bounce during hold.** Press, then at hold count 20 drop `BTN` to 0 for 3 cycles and return it to 1. → No `RELEASE`. `LONG_PRESS` is delayed by exactly 3 cycles, the time the hold counter spent frozen in RELEASE_WAIT.
6. **Mid-operation reset and polarity.** Assert `RST` at debounce count 5. → No `PRESS`, state returns to IDLE. Then set `ACTIVE_LOW`=1, drive `BTN` 1→0 and hold it. → `PRESS` fires after 10 edges.

Source files
------------

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM and registered
// level / press / release / long-press outputs for the LED toggle stage.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES   = 240000,
    parameter int unsigned LONG_PRESS_CYCLES = 12000000,
    parameter bit          ACTIVE_LOW        = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic BTN_STABLE,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG_PRESS
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = (LONG_PRESS_CYCLES > 0) ? $clog2(LONG_PRESS_CYCLES + 1) : 1;
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
    localparam bit LONG_EN = (LONG_PRESS_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               stable_q, stable_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               long_q, long_d;

    function automatic logic [DEB_W-1:0] deb_inc(input logic [DEB_W-1:0] v);
        return (v == DEB_MAX) ? v : v + DEB_W'(1);
    endfunction

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
        return (v == HOLD_MAX) ? v : v + HOLD_W'(1);
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        s1_d       = BTN ^ ACTIVE_LOW;
        s2_d       = s1_q;
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        stable_d   = stable_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s2_q) begin
                    state_d   = ST_PRESS_WAIT;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            ST_PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d   = ST_IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_inc(deb_cnt_q);
                    if (deb_cnt_d == DEB_MAX) begin
                        state_d    = ST_PRESSED;
                        deb_cnt_d  = '0;
                        hold_cnt_d = '0;
                        stable_d   = 1'b1;
                        press_d    = 1'b1;
                    end
                end
            end
            ST_PRESSED: begin
                // Hold time keeps running on the edge that starts release debouncing.
                hold_cnt_d = hold_inc(hold_cnt_q);
                if (LONG_EN && hold_cnt_q != HOLD_MAX && hold_cnt_d == HOLD_MAX) begin
                    long_d = 1'b1;
                end
                if (!s2_q) begin
                    state_d   = ST_RELEASE_WAIT;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            ST_RELEASE_WAIT: begin
                if (s2_q) begin
                    state_d   = ST_PRESSED;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_inc(deb_cnt_q);
                    if (deb_cnt_d == DEB_MAX) begin
                        state_d   = ST_IDLE;
                        deb_cnt_d = '0;
                        stable_d  = 1'b0;
                        release_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: state updates use <= so every flop samples pre-edge values.
        if (RST) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            state_q    <= ST_IDLE;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            stable_q   <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            stable_q   <= stable_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    assign BTN_STABLE = stable_q;
    assign PRESS      = press_q;
    assign RELEASE    = release_q;
    assign LONG_PRESS = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: stimulus queues expected pulse events with hand-computed
// cycle numbers; a negedge monitor pops and compares whenever a pulse appears.
module tb_button_debouncer;

    localparam int unsigned DEB  = 8;
    localparam int unsigned LONG = 32;

    typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic btn_al;
    logic stable0, press0, rel0, long0;
    logic stable1, press1, rel1, long1;

    int   cyc      = 0;
    logic rst_prev = 1'b1;
    int   checks   = 0;
    int   errors   = 0;
    logic lvl [2]  = '{1'b0, 1'b0};
    ev_t  exp_q0 [$];
    ev_t  exp_q1 [$];

    button_debouncer #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .ACTIVE_LOW       (1'b0)
    ) dut_hi (
        .CLK       (clk),
        .RST       (rst),
        .BTN       (btn),
        .BTN_STABLE(stable0),
        .PRESS     (press0),
        .RELEASE   (rel0),
        .LONG_PRESS(long0)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .ACTIVE_LOW       (1'b1)
    ) dut_al (
        .CLK       (clk),
        .RST       (rst),
        .BTN       (btn_al),
        .BTN_STABLE(stable1),
        .PRESS     (press1),
        .RELEASE   (rel1),
        .LONG_PRESS(long1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst;
    end

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic push(input int id, input ev_kind_e kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        if (id == 0) exp_q0.push_back(e);
        else         exp_q1.push_back(e);
    endtask

    task automatic mon(input int id, input logic press, input logic rel,
                       input logic lng, input logic stable);
        logic [2:0] p;
        ev_kind_e   k;
        ev_t        e;
        int         avail;
        p = {lng, rel, press};
        if (rst_prev) lvl[id] = 1'b0;
        if (p !== 3'b000) begin
            check($countones(p) == 1, $sformatf("inst%0d_single_pulse", id),
                  int'(p), 1);
            k = press ? EV_PRESS : (rel ? EV_RELEASE : EV_LONG);
            avail = (id == 0) ? exp_q0.size() : exp_q1.size();
            if (avail == 0) begin
                check(1'b0, $sformatf("inst%0d_unexpected_pulse", id), int'(k), -1);
            end else begin
                if (id == 0) e = exp_q0.pop_front();
                else         e = exp_q1.pop_front();
                check(k == e.kind, $sformatf("inst%0d_event_kind", id), int'(k), int'(e.kind));
                check(cyc == e.cyc, $sformatf("inst%0d_event_cycle", id), cyc, e.cyc);
                if (e.kind == EV_PRESS)   lvl[id] = 1'b1;
                if (e.kind == EV_RELEASE) lvl[id] = 1'b0;
            end
        end
        check(stable === lvl[id], $sformatf("inst%0d_btn_stable", id),
              int'(stable), int'(lvl[id]));
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            mon(0, press0, rel0, long0, stable0);
            mon(1, press1, rel1, long1, stable1);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        btn    = 1'b1;
        btn_al = 1'b1;

        // Reset held 3 cycles with the button pressed; press debounced afresh.
        wait_until(3);   rst = 1'b0;   push(0, EV_PRESS, 13);
        wait_until(20);  btn = 1'b0;   push(0, EV_RELEASE, 30);

        // Clean press and release.
        wait_until(40);  btn = 1'b1;   push(0, EV_PRESS, 50);
        wait_until(60);  btn = 1'b0;   push(0, EV_RELEASE, 70);

        // Seven-cycle glitch: one short of acceptance.
        wait_until(80);  btn = 1'b1;
        wait_until(87);  btn = 1'b0;

        // Bounce 1,0,1,1,0 then held.
        wait_until(100); btn = 1'b1;
        wait_until(101); btn = 1'b0;
        wait_until(102); btn = 1'b1;
        wait_until(104); btn = 1'b0;
        wait_until(105); btn = 1'b1;   push(0, EV_PRESS, 115);
        wait_until(130); btn = 1'b0;   push(0, EV_RELEASE, 140);

        // Long press held 60 cycles.
        wait_until(160); btn = 1'b1;   push(0, EV_PRESS, 170); push(0, EV_LONG, 202);
        wait_until(220); btn = 1'b0;   push(0, EV_RELEASE, 230);

        // Release bounce at hold count 20 delays long-press by 3 cycles.
        wait_until(250); btn = 1'b1;   push(0, EV_PRESS, 260);
        wait_until(280); btn = 1'b0;
        wait_until(283); btn = 1'b1;   push(0, EV_LONG, 295);
        wait_until(310); btn = 1'b0;   push(0, EV_RELEASE, 320);

        // Reset at debounce count 5 aborts silently.
        wait_until(340); btn = 1'b1;
        wait_until(347); rst = 1'b1;   btn = 1'b0;
        wait_until(349); rst = 1'b0;

        // Active-low instance: pressed reads low.
        wait_until(380); btn_al = 1'b0; push(1, EV_PRESS, 390);
        wait_until(400); btn_al = 1'b1; push(1, EV_RELEASE, 410);

        wait_until(430);
        check(exp_q0.size() == 0, "inst0_events_outstanding", exp_q0.size(), 0);
        check(exp_q1.size() == 0, "inst1_events_outstanding", exp_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
